// File: rtl/data_memory_pipe_if.sv
// Request/response bus between the LSU/MEM stage and the pipelined data memory.
// The master drives requests and stall; the slave returns ready and the response.
interface data_memory_pipe_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_mask;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_mask, stall,
    input  req_ready, resp_valid, resp_rdata, resp_fault
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_mask, stall,
    output req_ready, resp_valid, resp_rdata, resp_fault
  );
endinterface

// File: rtl/data_memory_pipe.sv
// Pipelined word-organised data RAM with RV32 load/store sizing, byte-lane writes,
// configurable read latency, stall-aware handshake and a saturating fault counter.
module data_memory_pipe #(
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned FAULT_CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  data_memory_pipe_if.slave      bus,
  output logic [FAULT_CNT_W-1:0] fault_count
);

  localparam int unsigned AddrW = $clog2(DEPTH_WORDS);

  logic [31:0]      mem [DEPTH_WORDS];
  logic             accept;
  logic             fault;
  logic             out_of_range;
  logic             misaligned;
  logic             bad_mask;
  logic [AddrW-1:0] idx;
  logic [31:0]      rd_word;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [31:0]      ld_data;
  logic [31:0]      resp_data_d;
  logic [31:0]      wr_data;
  logic [3:0]       wr_be;

  logic [READ_LATENCY-1:0] vld_q;
  logic [READ_LATENCY-1:0] flt_q;
  logic [31:0]             dat_q [READ_LATENCY];
  logic [FAULT_CNT_W-1:0]  fault_cnt_q;

  assign bus.req_ready = !rst && !bus.stall;
  assign accept        = bus.req_valid && bus.req_ready;
  assign idx           = bus.req_addr[AddrW+1:2];
  assign out_of_range  = bus.req_addr[31:2] >= 30'(DEPTH_WORDS);
  assign fault         = out_of_range || misaligned || bad_mask;

  always_comb begin
    misaligned = 1'b0;
    bad_mask   = 1'b0;
    case (bus.req_mask)
      3'b000, 3'b100: misaligned = 1'b0;
      3'b001, 3'b101: misaligned = bus.req_addr[0];
      3'b010:         misaligned = |bus.req_addr[1:0];
      default:        bad_mask   = 1'b1;
    endcase
    // Unsigned sizes have no meaning for stores.
    if (bus.req_we && bus.req_mask[2]) bad_mask = 1'b1;
  end

  // Asynchronous read: any store accepted on an earlier edge is already in the array.
  assign rd_word = mem[idx];
  assign ld_byte = rd_word[{bus.req_addr[1:0], 3'b000} +: 8];
  assign ld_half = bus.req_addr[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    ld_data = '0;
    case (bus.req_mask)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'h0, ld_half};
      3'b010:  ld_data = rd_word;
      default: ld_data = '0;
    endcase
  end

  assign resp_data_d = (accept && !bus.req_we && !fault) ? ld_data : '0;

  always_comb begin
    wr_be   = 4'b1111;
    wr_data = bus.req_wdata;
    case (bus.req_mask[1:0])
      2'b00: begin
        wr_be   = 4'b0001 << bus.req_addr[1:0];
        wr_data = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        wr_be   = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        wr_be   = 4'b1111;
        wr_data = bus.req_wdata;
      end
    endcase
  end

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (accept && bus.req_we && !fault) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      flt_q <= '0;
      for (int i = 0; i < int'(READ_LATENCY); i++) dat_q[i] <= '0;
    end else if (!bus.stall) begin
      vld_q[0] <= accept;
      flt_q[0] <= accept && fault;
      dat_q[0] <= resp_data_d;
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        vld_q[i] <= vld_q[i-1];
        flt_q[i] <= flt_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fault_cnt_q <= '0;
    end else if (accept && fault && (fault_cnt_q != '1)) begin
      fault_cnt_q <= fault_cnt_q + 1'b1;
    end
  end

  assign bus.resp_valid = vld_q[READ_LATENCY-1];
  assign bus.resp_fault = flt_q[READ_LATENCY-1];
  assign bus.resp_rdata = dat_q[READ_LATENCY-1];
  assign fault_count    = fault_cnt_q;

endmodule

// File: tb/tb_data_memory_pipe.sv
// Directed bench: one shared request stream drives an L=1, an L=3 and a 4-bit-counter
// instance; each check looks at the instance whose behaviour is being exercised.
module tb_data_memory_pipe;

  localparam int unsigned Depth = 64;
  localparam logic [2:0] MB  = 3'b000;
  localparam logic [2:0] MH  = 3'b001;
  localparam logic [2:0] MW  = 3'b010;
  localparam logic [2:0] MBU = 3'b100;
  localparam logic [2:0] MHU = 3'b101;

  logic        clk;
  logic        rst1, rst3, rsts;
  logic        req_valid, req_we, stall;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_mask;
  logic [15:0] fc1, fc3;
  logic [3:0]  fcs;
  int          n_cmp;
  int          n_fail;
  logic [31:0] exp_w [4];

  data_memory_pipe_if bus1 ();
  data_memory_pipe_if bus3 ();
  data_memory_pipe_if buss ();

  assign bus1.req_valid = req_valid;
  assign bus1.req_we    = req_we;
  assign bus1.req_addr  = req_addr;
  assign bus1.req_wdata = req_wdata;
  assign bus1.req_mask  = req_mask;
  assign bus1.stall     = stall;
  assign bus3.req_valid = req_valid;
  assign bus3.req_we    = req_we;
  assign bus3.req_addr  = req_addr;
  assign bus3.req_wdata = req_wdata;
  assign bus3.req_mask  = req_mask;
  assign bus3.stall     = stall;
  assign buss.req_valid = req_valid;
  assign buss.req_we    = req_we;
  assign buss.req_addr  = req_addr;
  assign buss.req_wdata = req_wdata;
  assign buss.req_mask  = req_mask;
  assign buss.stall     = stall;

  data_memory_pipe #(.DEPTH_WORDS(Depth), .READ_LATENCY(1), .FAULT_CNT_W(16)) dut1 (
    .clk(clk), .rst(rst1), .bus(bus1), .fault_count(fc1)
  );
  data_memory_pipe #(.DEPTH_WORDS(Depth), .READ_LATENCY(3), .FAULT_CNT_W(16)) dut3 (
    .clk(clk), .rst(rst3), .bus(bus3), .fault_count(fc3)
  );
  data_memory_pipe #(.DEPTH_WORDS(Depth), .READ_LATENCY(1), .FAULT_CNT_W(4)) duts (
    .clk(clk), .rst(rsts), .bus(buss), .fault_count(fcs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic v, input logic we, input logic [2:0] m,
                    input logic [31:0] a, input logic [31:0] d);
    req_valid = v;
    req_we    = we;
    req_mask  = m;
    req_addr  = a;
    req_wdata = d;
    step();
  endtask

  task automatic idle();
    op(1'b0, 1'b0, MW, 32'h0, 32'h0);
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    exp_w[0] = 32'h1000_0000;
    exp_w[1] = 32'h1000_0001;
    exp_w[2] = 32'h1000_0002;
    exp_w[3] = 32'h1234_0003;
    rst1 = 1'b1; rst3 = 1'b1; rsts = 1'b1; stall = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_mask = MW; req_addr = '0; req_wdata = '0;
    step();
    step();
    check("rst_valid", 32'(bus1.resp_valid), 32'd0);
    check("rst_rdata", bus1.resp_rdata, 32'd0);
    check("rst_fault", 32'(bus1.resp_fault), 32'd0);
    check("rst_fcnt", 32'(fc1), 32'd0);
    check("rst_ready", 32'(bus1.req_ready), 32'd0);
    rst1 = 1'b0; rst3 = 1'b0; rsts = 1'b0;
    #1;
    check("ready_after_rst", 32'(bus1.req_ready), 32'd1);

    // Words 0..3 seeded for the later L=3 streams.
    for (int i = 0; i < 4; i++) begin
      op(1'b1, 1'b1, MW, 32'(4 * i), 32'h1000_0000 + 32'(i));
      if (i == 0) begin
        check("sw_resp_valid", 32'(bus1.resp_valid), 32'd1);
        check("sw_resp_rdata", bus1.resp_rdata, 32'd0);
      end
    end
    op(1'b1, 1'b1, MW, 32'h10, 32'hDEAD_BEEF);
    op(1'b1, 1'b0, MW, 32'h10, 32'h0);
    check("lw_l1_valid", 32'(bus1.resp_valid), 32'd1);
    check("lw_l1_rdata", bus1.resp_rdata, 32'hDEAD_BEEF);
    check("lw_l1_fault", 32'(bus1.resp_fault), 32'd0);
    idle();
    check("bubble_valid", 32'(bus1.resp_valid), 32'd0);
    check("bubble_rdata", bus1.resp_rdata, 32'd0);

    op(1'b1, 1'b1, MB, 32'h12, 32'hAABB_CC55);
    op(1'b1, 1'b0, MW, 32'h10, 32'h0);
    check("sb_lw", bus1.resp_rdata, 32'hDE55_BEEF);
    op(1'b1, 1'b0, MB, 32'h13, 32'h0);
    check("lb_13", bus1.resp_rdata, 32'hFFFF_FFDE);
    op(1'b1, 1'b0, MBU, 32'h13, 32'h0);
    check("lbu_13", bus1.resp_rdata, 32'h0000_00DE);
    op(1'b1, 1'b0, MH, 32'h12, 32'h0);
    check("lh_12", bus1.resp_rdata, 32'hFFFF_DE55);
    op(1'b1, 1'b0, MHU, 32'h12, 32'h0);
    check("lhu_12", bus1.resp_rdata, 32'h0000_DE55);
    op(1'b1, 1'b0, MB, 32'h10, 32'h0);
    check("lb_10", bus1.resp_rdata, 32'hFFFF_FFEF);
    op(1'b1, 1'b1, MH, 32'h0E, 32'hFFFF_1234);
    op(1'b1, 1'b0, MW, 32'h0C, 32'h0);
    check("sh_upper", bus1.resp_rdata, exp_w[3]);

    op(1'b1, 1'b0, MW, 32'h11, 32'h0);
    check("flt_lw_mis", 32'(bus1.resp_fault), 32'd1);
    check("flt_lw_data", bus1.resp_rdata, 32'd0);
    op(1'b1, 1'b1, MH, 32'h13, 32'h0000_FFFF);
    check("flt_sh_mis", 32'(bus1.resp_fault), 32'd1);
    op(1'b1, 1'b0, 3'b011, 32'h10, 32'h0);
    check("flt_mask011", 32'(bus1.resp_fault), 32'd1);
    check("flt_mask_data", bus1.resp_rdata, 32'd0);
    op(1'b1, 1'b1, MB, 32'(Depth * 4), 32'h77);
    check("flt_sb_oor", 32'(bus1.resp_fault), 32'd1);
    op(1'b1, 1'b0, MW, 32'h10, 32'h0);
    check("post_flt_lw", bus1.resp_rdata, 32'hDE55_BEEF);
    check("post_flt_ok", 32'(bus1.resp_fault), 32'd0);
    op(1'b1, 1'b0, MW, 32'h0, 32'h0);
    check("oor_no_wrap", bus1.resp_rdata, exp_w[0]);
    check("fcnt_4", 32'(fc1), 32'd4);

    idle(); idle(); idle();
    for (int i = 0; i < 7; i++) begin
      if (i < 4) op(1'b1, 1'b0, MW, 32'(4 * i), 32'h0);
      else idle();
      if (i >= 2 && i < 6) begin
        check("l3_valid", 32'(bus3.resp_valid), 32'd1);
        check("l3_rdata", bus3.resp_rdata, exp_w[i-2]);
      end else begin
        check("l3_idle", 32'(bus3.resp_valid), 32'd0);
      end
    end

    op(1'b1, 1'b0, MW, 32'h0, 32'h0);
    op(1'b1, 1'b0, MW, 32'h4, 32'h0);
    op(1'b1, 1'b0, MW, 32'h8, 32'h0);
    check("st_r0", bus3.resp_rdata, exp_w[0]);
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      op(1'b1, 1'b0, MW, 32'hC, 32'h0);
      check("st_ready", 32'(bus3.req_ready), 32'd0);
      check("st_hold_v", 32'(bus3.resp_valid), 32'd1);
      check("st_hold_d", bus3.resp_rdata, exp_w[0]);
    end
    stall = 1'b0;
    op(1'b1, 1'b0, MW, 32'hC, 32'h0);
    check("st_r1", bus3.resp_rdata, exp_w[1]);
    idle();
    check("st_r2", bus3.resp_rdata, exp_w[2]);
    idle();
    check("st_r3", bus3.resp_rdata, exp_w[3]);
    check("st_r3_v", 32'(bus3.resp_valid), 32'd1);
    idle();
    check("st_no_dup", 32'(bus3.resp_valid), 32'd0);

    op(1'b1, 1'b1, MW, 32'h20, 32'hCAFE_F00D);
    idle(); idle(); idle();
    op(1'b1, 1'b0, MW, 32'h20, 32'h0);
    op(1'b1, 1'b0, MW, 32'h10, 32'h0);
    rst3 = 1'b1;
    op(1'b1, 1'b0, MW, 32'h20, 32'h0);
    check("mid_rst_valid", 32'(bus3.resp_valid), 32'd0);
    check("mid_rst_fcnt", 32'(fc3), 32'd0);
    check("mid_rst_ready", 32'(bus3.req_ready), 32'd0);
    rst3 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle();
      check("post_rst_quiet", 32'(bus3.resp_valid), 32'd0);
    end
    op(1'b1, 1'b0, MW, 32'h20, 32'h0);
    idle();
    idle();
    check("rst_mem_kept_v", 32'(bus3.resp_valid), 32'd1);
    check("rst_mem_kept", bus3.resp_rdata, 32'hCAFE_F00D);

    rsts = 1'b1;
    idle();
    rsts = 1'b0;
    check("sat_start", 32'(fcs), 32'd0);
    for (int i = 1; i <= 17; i++) begin
      op(1'b1, 1'b0, MW, 32'h11, 32'h0);
      if (i == 5)  check("sat_5", 32'(fcs), 32'd5);
      if (i == 15) check("sat_15", 32'(fcs), 32'hF);
    end
    check("sat_17", 32'(fcs), 32'hF);
    check("sat_flt", 32'(buss.resp_fault), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/data_memory_pipe.md
Name: data_memory_pipe

Overview:
Parametrised, pipelined successor to the single-cycle data memory: word-organised RAM with RV32 load/store size encoding, true byte-lane writes that preserve the untouched bytes, configurable read latency, valid/ready request handshake with stall, and fault detection. Sits between the LSU/MEM stage and the core's writeback path. Memory contents are not reset; only the control pipeline is.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words; power of two, 16..65536
READ_LATENCY, 1, edges from request acceptance to response, 1..4
FAULT_CNT_W, 16, width of saturating fault counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  request accepted on edge when req_valid & req_ready
req_we  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data, bytes taken from LSBs
req_mask  input  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
stall  input  1  freezes response pipeline and blocks acceptance
resp_valid  output  1  response present (one per accepted request, loads and stores)
resp_rdata  output  32  load data, extended per mask; 0 for stores and faults
resp_fault  output  1  accepted request was faulted
fault_count  output  FAULT_CNT_W  saturating count of faulted requests

Behaviour:
- Clock is clk; reset is synchronous and active-high on rst. Reset: resp_valid=0, resp_rdata=0, resp_fault=0, fault_count=0, all pipeline valid bits cleared, req_ready=0 while rst=1. RAM contents retained across reset.
- req_ready = !rst & !stall. Accept = req_valid & req_ready on a rising edge.
- Fault if any of: word index req_addr[31:2] >= DEPTH_WORDS; mask 001/101 with addr[0]=1; mask 010 with addr[1:0]!=0; mask in {011,110,111}; store with mask 100 or 101.
- Store (non-faulted): on acceptance edge write only the addressed lanes. B writes lane addr[1:0] with wdata[7:0]. H writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0]. W writes all four lanes. Other bytes unchanged. Faulted stores do not write.
- Load: word sampled from RAM on acceptance edge, after any write at an earlier edge. Loads see all stores accepted before them. Byte/halfword selected by addr[1:0], then sign- or zero-extended per mask. Faulted load returns 0.
- Latency: a request accepted at edge t produces resp_valid=1 after edge t+READ_LATENCY-1, for exactly one non-stalled cycle. Responses leave in acceptance order; throughput is one per cycle.
- Stall: while stall=1, pipeline stages and outputs hold their values. resp_valid stays asserted if it was set, and no new request is accepted. Consumer takes the response only when stall=0.
- Non-accepted cycles insert bubbles; resp_valid=0 for bubbles, with resp_rdata=0 and resp_fault=0.
- fault_count increments on the acceptance edge of each faulted request and saturates at all-ones.
- Reset mid-operation: in-flight responses are discarded and never emitted. A store accepted on the edge before reset completes. No request is accepted on an edge where rst=1.

Test Plan:
- L=1: SW 0xDEADBEEF @0x10, then LW @0x10 on the next cycle -> load resp_valid one edge after acceptance, rdata=0xDEADBEEF, fault=0.
- Byte lanes: after word 0xDEADBEEF @0x10, SB 0x55 @0x12 then LW @0x10 -> 0xDE55BEEF. LB @0x13 -> 0xFFFFFFDE. LBU @0x13 -> 0x000000DE. LH @0x12 -> 0xFFFFDE55.
- Faults: LW @0x11, SH @0x13, mask 011, SB @ (DEPTH_WORDS*4) -> each gives resp_fault=1 with rdata=0. The follow-up LW @0x10 is unchanged. fault_count=4.
- L=3 back-to-back: 4 consecutive LW to words 0..3 -> resp_valid on 4 consecutive cycles starting 2 cycles after the first acceptance, in order. Assert stall for 2 cycles mid-stream -> req_ready=0, outputs frozen, no response lost or duplicated.
- Reset: L=3, assert rst with 2 loads in flight -> no response emitted, resp_valid=0, fault_count=0, and memory written before reset still reads back.
- Saturation: FAULT_CNT_W=4, 17 faulted requests -> fault_count stays at 0xF.
